// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and widths for the UART transmit arbiter
package uart_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;
    localparam int BYTE_W = 8;
    localparam int CNT_W  = 8;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request above the last grant with wrap
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   last,
    output logic [2:0]   win,
    output logic         any
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    int idx;
    // scan from the farthest candidate to the nearest so the closest one after last wins
    always_comb begin
        win = last;
        idx = 0;
        for (int k = N; k >= 1; k--) begin
            idx = int'(last) + k;
            idx = (idx >= N) ? idx - N : idx;
            win = req[idx[IW-1:0]] ? 3'(idx) : win;
        end
    end
    assign any = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin owner of the UART transmit byte path with burst cap and stall timeout
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [BYTE_W*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [2:0]                grant_id,
    output logic                      busy,
    output logic                      timeout_evt
);
    state_t state, state_nx;
    logic [CNT_W-1:0] burst_cnt, idle_cnt;
    logic [N_REQ-1:0] owner_mask;
    logic [BYTE_W-1:0] own_data;
    logic own_valid, own_last, can_take, accept, burst_end, stall_end, any;
    logic [2:0] pick;

    rr_pick #(.N(N_REQ)) u_pick (
        .req  (req_valid),
        .last (grant_id),
        .win  (pick),
        .any  (any)
    );

    assign busy = state == XFER;

    // owner's view of the request bus, handshake strobes, release conditions and next state
    always_comb begin
        owner_mask = N_REQ'(1) << grant_id;
        own_valid  = |(req_valid & owner_mask);
        own_last   = |(req_last & owner_mask);
        own_data   = BYTE_W'(req_data >> {grant_id, 3'b000});
        can_take   = busy && (!tx_valid || tx_ready);
        accept     = can_take && own_valid;
        burst_end  = accept && (own_last || burst_cnt == CNT_W'(MAX_BURST - 1));
        stall_end  = busy && !own_valid && idle_cnt == CNT_W'(TIMEOUT - 1);
        req_ready  = can_take ? owner_mask : '0;
        state_nx   = busy ? ((burst_end || stall_end) ? IDLE : XFER) : (any ? XFER : IDLE);
    end

    // state register
    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

    // output byte register, grant register and the burst/idle counters
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            grant_id    <= 3'(N_REQ - 1);
            burst_cnt   <= '0;
            idle_cnt    <= '0;
            timeout_evt <= 1'b0;
        end else begin
            timeout_evt <= stall_end;
            tx_valid    <= accept || (tx_valid && !tx_ready);
            if (accept) tx_data <= own_data;
            if (!busy && any) grant_id <= pick;
            burst_cnt   <= !busy ? '0 : burst_cnt + CNT_W'(accept);
            idle_cnt    <= (!busy || own_valid) ? '0 : idle_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random checks against a cycle-level behavioural model
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int MB = 16;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [2:0]  grant_id;
    logic        busy;
    logic        timeout_evt;

    uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_evt (timeout_evt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model state: expected owner, pending output byte and release bookkeeping
    logic       m_busy;
    int         m_g;
    logic       m_txv;
    logic [7:0] m_data;
    logic       m_to;
    int         m_cnt;
    int         m_idle;
    bit         chk_en = 0;

    // requester byte sources: {last, byte} per entry, ring-indexed
    logic [8:0] gb [N][1024];
    int         hd [N];
    int         tl [N];
    logic       hold [N];
    int         sq [N];
    int         nxt [N];
    int         n_push, n_out, to_seen;
    int         glog [$];
    int         exp_q [$];
    logic       pb = 1'b0;
    bit         seq_en = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_g    = N - 1;
        m_txv  = 1'b0;
        m_data = 8'h00;
        m_to   = 1'b0;
        m_cnt  = 0;
        m_idle = 0;
    endtask

    task automatic model_check();
        logic [3:0] rdy;
        rdy = (m_busy && (!m_txv || tx_ready)) ? 4'(1 << m_g) : 4'b0;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("grant_id", 32'(grant_id), 32'(m_g));
        chk("tx_valid", 32'(tx_valid), 32'(m_txv));
        chk("tx_data", 32'(tx_data), 32'(m_data));
        chk("req_ready", 32'(req_ready), 32'(rdy));
        chk("timeout_evt", 32'(timeout_evt), 32'(m_to));
    endtask

    task automatic model_next();
        logic acc;
        bit   found;
        int   g;
        if (rst) begin
            model_reset();
            return;
        end
        g   = m_g;
        acc = m_busy && (!m_txv || tx_ready) && req_valid[g];
        m_to = 1'b0;
        if (m_busy) begin
            if (acc) begin
                m_cnt++;
                m_idle = 0;
                if (req_last[g] || m_cnt == MB) m_busy = 1'b0;
            end else if (!req_valid[g]) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_busy = 1'b0;
                    m_to   = 1'b1;
                end
            end else begin
                m_idle = 0;
            end
        end else if (req_valid != 4'b0) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && req_valid[(m_g + k) % N]) begin
                    found = 1;
                    g = (m_g + k) % N;
                end
            end
            m_g    = g;
            m_busy = 1'b1;
            m_cnt  = 0;
            m_idle = 0;
        end
        if (acc) begin
            m_txv  = 1'b1;
            m_data = req_data[8*g +: 8];
        end else if (tx_ready) begin
            m_txv = 1'b0;
        end
    endtask

    task automatic push(input int i, input logic [7:0] b, input logic l);
        gb[i][tl[i] % 1024] = {l, b};
        tl[i]++;
        n_push++;
    endtask

    task automatic drive();
        logic v;
        for (int i = 0; i < N; i++) begin
            v = (hd[i] < tl[i]) && !hold[i];
            req_valid[i] = v;
            req_data[8*i +: 8] = v ? gb[i][hd[i] % 1024][7:0] : 8'($urandom);
            req_last[i] = v ? gb[i][hd[i] % 1024][8] : 1'($urandom);
        end
    endtask

    task automatic clear();
        n_push  = 0;
        n_out   = 0;
        to_seen = 0;
        glog.delete();
        for (int i = 0; i < N; i++) begin
            hd[i]   = 0;
            tl[i]   = 0;
            hold[i] = 1'b0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (chk_en) model_check();
        model_next();
        for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) hd[i]++;
        if (tx_valid && tx_ready) begin
            n_out++;
            if (seq_en) begin
                chk("seq", 32'(tx_data[5:0]), 32'(nxt[tx_data[7:6]] % 64));
                nxt[tx_data[7:6]]++;
            end
        end
        if (timeout_evt) to_seen++;
        if (busy && !pb) glog.push_back(int'(grant_id));
        pb = busy;
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input string tag, input int budget);
        int c;
        bit done;
        c = 0;
        done = 0;
        while (!done && c < budget) begin
            cycle();
            c++;
            done = !busy && !tx_valid;
            for (int i = 0; i < N; i++) if (hd[i] < tl[i]) done = 0;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic chk_glog(input string tag);
        chk({tag, "_count"}, 32'(glog.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            chk(tag, 32'(glog.size() > k ? glog[k] : -1), 32'(exp_q[k]));
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_tx_valid"}, 32'(tx_valid), 32'd0);
        chk({pfx, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({pfx, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({pfx, "_grant_id"}, 32'(grant_id), 32'(N - 1));
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_timeout_evt"}, 32'(timeout_evt), 32'd0);
    endtask

    initial begin
        model_reset();
        clear();
        rst = 1'b1;
        repeat (3) cycle();
        chk_en = 1;
        rst = 1'b0;
        chk_reset("reset");

        // single burst from requester 2
        clear();
        push(2, 8'h41, 1'b0);
        push(2, 8'h42, 1'b0);
        push(2, 8'h43, 1'b1);
        drive();
        cycle();
        chk("single_busy_rise", 32'(busy), 32'd1);
        chk("single_grant", 32'(grant_id), 32'd2);
        cycle();
        chk("single_b0", 32'(tx_data), 32'h41);
        cycle();
        chk("single_b1", 32'(tx_data), 32'h42);
        cycle();
        chk("single_b2", 32'(tx_data), 32'h43);
        drain("single_drain", 50);
        chk("single_idle", 32'(busy), 32'd0);
        chk("single_hold_gid", 32'(grant_id), 32'd2);
        chk("single_bytes", 32'(n_out), 32'(n_push));

        // round-robin fairness after a fresh reset
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        clear();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N; i++) begin
                push(i, 8'(16 * i + 2 * r), 1'b0);
                push(i, 8'(16 * i + 2 * r + 1), 1'b1);
            end
        drive();
        drain("rr_drain", 200);
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
        chk_glog("rr_order");
        chk("rr_bytes", 32'(n_out), 32'(n_push));

        // burst cap: requester 1 streams 20 bytes, requester 3 waits
        clear();
        for (int k = 0; k < 20; k++) push(1, 8'(8'h10 + k), k == 19);
        push(3, 8'hA0, 1'b0);
        push(3, 8'hA1, 1'b1);
        drive();
        drain("cap_drain", 200);
        exp_q = '{1, 3, 1};
        chk_glog("cap_order");
        chk("cap_bytes", 32'(n_out), 32'(n_push));

        // long backpressure mid-burst is never a timeout
        clear();
        for (int k = 0; k < 10; k++) push(0, 8'(8'h60 + k), k == 9);
        drive();
        repeat (4) cycle();
        tx_ready = 1'b0;
        repeat (100) cycle();
        tx_ready = 1'b1;
        drain("bp_drain", 100);
        chk("bp_no_timeout", 32'(to_seen), 32'd0);
        chk("bp_bytes", 32'(n_out), 32'(n_push));

        // owner 0 stalls mid-burst while requester 1 waits
        clear();
        for (int k = 0; k < 3; k++) push(0, 8'(8'h70 + k), 1'b0);
        drive();
        repeat (6) cycle();
        push(1, 8'hB0, 1'b0);
        push(1, 8'hB1, 1'b1);
        drive();
        drain("to_drain", 300);
        chk("to_events", 32'(to_seen), 32'd1);
        exp_q = '{0, 1};
        chk_glog("to_order");
        chk("to_bytes", 32'(n_out), 32'(n_push));

        // reset mid-burst with a pending byte held by backpressure
        clear();
        for (int k = 0; k < 5; k++) push(2, 8'(8'h80 + k), k == 4);
        drive();
        cycle();
        cycle();
        tx_ready = 1'b0;
        cycle();
        cycle();
        chk("mid_pending", 32'(tx_valid), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk_reset("mid_reset");
        clear();
        push(0, 8'h90, 1'b0);
        push(0, 8'h91, 1'b1);
        push(2, 8'h92, 1'b0);
        push(2, 8'h93, 1'b1);
        tx_ready = 1'b1;
        drive();
        drain("mid_drain", 100);
        exp_q = '{0, 2};
        chk_glog("mid_order");

        // random traffic: bursts with and without last, stalls, random backpressure
        clear();
        for (int i = 0; i < N; i++) begin
            sq[i]  = 0;
            nxt[i] = 0;
        end
        seq_en = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hd[i] == tl[i] && $urandom_range(0, 7) == 0) begin
                    int len;
                    bit nl;
                    len = $urandom_range(1, 20);
                    nl  = $urandom_range(0, 3) == 0;
                    for (int b = 0; b < len; b++) begin
                        push(i, {2'(i), 6'(sq[i])}, b == len - 1 && !nl);
                        sq[i]++;
                    end
                end
                if ($urandom_range(0, 99) == 0) hold[i] = !hold[i];
            end
            tx_ready = $urandom_range(0, 3) != 0;
            drive();
            cycle();
        end
        for (int i = 0; i < N; i++) hold[i] = 1'b0;
        tx_ready = 1'b1;
        drive();
        drain("rand_drain", 3000);
        chk("rand_bytes", 32'(n_out), 32'(n_push));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmit byte path (transmit FIFO write port feeding the transmitter) among several on-chip requesters. Each requester sends bursts of bytes. The arbiter grants one requester at a time and holds the grant until that burst ends, hits the burst cap, or stalls past a timeout. It sits between the requesters and the transmit FIFO, in the `sys_clk` domain.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `MAX_BURST`, default 16: maximum bytes per grant before forced release (1..255).
- `TIMEOUT`, default 64: idle cycles tolerated mid-burst before release (1..255).
- `clk` in 1: system clock, one clock domain.
- `rst` in 1: synchronous reset, active-high.
- `req_valid` in N_REQ: per-requester byte valid.
- `req_data` in 8*N_REQ: byte of requester i at bits [8i+7:8i].
- `req_last` in N_REQ: marks the final byte of a burst; qualified by valid.
- `req_ready` out N_REQ: per-requester accept.
- `tx_data` out 8: byte to the transmit FIFO.
- `tx_valid` out 1: `tx_data` valid (FIFO write request).
- `tx_ready` in 1: FIFO can accept; wired to `!tfull`.
- `grant_id` out 3: index of the current owner; holds the last owner when idle.
- `busy` out 1: high while state is XFER.
- `timeout_evt` out 1: one-cycle pulse when a grant is released by timeout.

## Operation
- **States**
  - IDLE: no owner.
  - XFER: owner `grant_id` may push bytes.
- **IDLE → XFER**
  - Taken when any `req_valid` is high.
  - Winner: the first asserted index searching upward from `grant_id+1`, wrapping modulo N_REQ. After reset the search starts at 0.
  - The winner is registered into `grant_id`. Burst counter and idle counter clear.
- **Transfer rules in XFER**
  - `req_ready[g] = busy && (!tx_valid || tx_ready)` for the owner g. All other `req_ready` bits are 0.
  - Requester accept: `req_valid[g] && req_ready[g]` loads `tx_data`/`tx_valid` from requester g on the next edge.
  - A downstream handshake `tx_valid && tx_ready` with no new accept clears `tx_valid`.
  - `tx_data` holds its value while `tx_valid && !tx_ready`.
- **Burst counter**
  - 8-bit, increments per accept.
  - Release (XFER → IDLE) occurs on the accept where `req_last` is high or the counter reaches MAX_BURST-1.
- **Idle counter**
  - 8-bit. Increments each XFER cycle in which the owner has `req_valid` low; clears on any owner valid.
  - At TIMEOUT-1 the arbiter releases and pulses `timeout_evt`.
  - The counter does not run while the owner has valid high but is blocked by `!tx_ready`. Backpressure is never a timeout.
- **Draining on release:** a pending `tx_valid` byte stays registered until downstream accepts it, in IDLE as well. No new grant's byte is accepted before that pending byte drains; the `req_ready` formula enforces this.
- **Byte integrity**
  - Bytes are never dropped, duplicated or reordered.
  - Bytes from two requesters never interleave within a burst.

## Timing
- **Reset values:**
  - `tx_valid` = 0, `tx_data` = 0
  - `req_ready` = 0
  - `grant_id` = N_REQ-1, so the first search starts at 0
  - `busy` = 0, `timeout_evt` = 0
  - state = IDLE
- **Latency:**
  - Request to grant: 1 cycle. `req_valid` seen in IDLE gives `busy`=1 the next cycle.
  - Requester accept to `tx_valid`: 1 cycle.
- **Throughput:**
  - 1 byte/cycle while `tx_ready` is held high.
  - One-cycle IDLE bubble between consecutive grants.
- **Simultaneous events:**
  - Last byte accepted while other requesters are pending: release, then rotate next.
  - `req_last` on the MAX_BURST-th byte: a single release.
  - A requester dropping valid without `req_last`: only the timeout releases it.
- **Reset mid-burst:** everything returns to reset values on the next edge, and a pending `tx_valid` byte is discarded. Requesters must restart bursts.
- **Illegal input:** `req_last` without `req_valid` is ignored.

## Structure
- **Shared package `uart_pkg`:**
  - State encoding: IDLE=1'b0, XFER=1'b1.
  - Byte width constant 8.
  - Counter width 8.
- **Sub-module `rr_pick`:** combinational round-robin priority picker (request vector and last grant in; winner index and `any` out).
- The FSM, counters and output register stay in `uart_tx_arbiter`.

## Test plan
- **Single burst:** requester 2 sends 0x41,0x42,0x43 (last on 0x43), `tx_ready`=1 → `busy` rises 1 cycle after valid; `tx_data` shows 0x41..0x43 on 3 consecutive cycles; IDLE afterwards; `grant_id`=2.
- **Round-robin fairness:** all 4 requesters hold 2-byte bursts continuously → grant order 0,1,2,3,0, each burst uninterleaved, one bubble cycle between grants.
- **Burst cap:** MAX_BURST=16, requester 1 streams 20 bytes with no `req_last` while requester 3 waits → release after 16 bytes; requester 3 granted next; requester 1 regains later and sends the remaining 4.
- **Backpressure:** `tx_ready` low for 100 cycles mid-burst with TIMEOUT=64 → `tx_data` held stable, no `timeout_evt`, no loss; burst completes after `tx_ready` returns.
- **Timeout:** owner 0 drops valid mid-burst, requester 1 pending → `timeout_evt` pulse exactly 64 idle cycles later; requester 1 granted on the following cycle.
- **Reset mid-burst:** assert `rst` 1 cycle during requester 2's burst with `tx_valid`=1 and `tx_ready`=0 → next cycle all outputs at reset values; the next request from 0 is granted first.
